// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   clog2                : ceiling log2 helper for sizing
//   in_range             : inclusive bound check used on load values
package counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned res;
    longint unsigned v;
    res = 0;
    v   = (value > 64'd0) ? value - 64'd1 : 64'd0;
    while (v > 64'd0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Inclusive range check: lo <= value <= hi.
  function automatic logic in_range(input longint value, input longint lo, input longint hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/status bundle of the up/down counter.
//   master : drives clear/load/load_value/enable/increment/decrement/step,
//            observes count and flags
//   slave  : the counter itself
interface updown_counter_param_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);

  logic              clear;
  logic              load;
  logic [WIDTH-1:0]  load_value;
  logic              enable;
  logic              increment;
  logic              decrement;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              at_max;
  logic              at_min;
  logic              overflow;
  logic              underflow;
  logic              load_err;
  logic              sticky_ovf;

  modport master (
    output clear, load, load_value, enable, increment, decrement, step,
    input  count, at_max, at_min, overflow, underflow, load_err, sticky_ovf
  );

  modport slave (
    input  clear, load, load_value, enable, increment, decrement, step,
    output count, at_max, at_min, overflow, underflow, load_err, sticky_ovf
  );

endinterface

// File: rtl/updown_counter_next.sv
// Combinational next-count calculation for one up or down step.
//   count      : current count
//   up / down  : qualified direction (at most one set)
//   step       : step magnitude
//   next_count : wrapped or clamped result
//   ovf / unf  : raw result left [MIN_VAL, MAX_VAL] upward / downward
module updown_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = (32'd1 << WIDTH) - 32'd1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0]  count,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  next_count,
  output logic              ovf,
  output logic              unf
);

  // One extra bit beyond count+step keeps signed intermediates exact.
  localparam int unsigned AW = WIDTH + STEP_W + 1;

  localparam logic signed [AW-1:0] MIN_S   = AW'(MIN_VAL);
  localparam logic signed [AW-1:0] MAX_S   = AW'(MAX_VAL);
  localparam logic signed [AW-1:0] RANGE_S = AW'(MAX_VAL - MIN_VAL + 32'd1);

  logic signed [AW-1:0] cnt_s;
  logic signed [AW-1:0] stp_s;
  logic signed [AW-1:0] raw;
  logic signed [AW-1:0] rem;

  assign cnt_s = AW'(count);
  assign stp_s = AW'(step);

  // Raw step, bound detection, then wrap-or-clamp.
  always_comb begin
    raw        = cnt_s;
    rem        = '0;
    ovf        = 1'b0;
    unf        = 1'b0;
    next_count = count;

    if (up) begin
      raw = cnt_s + stp_s;
    end else if (down) begin
      raw = cnt_s - stp_s;
    end

    ovf = up   && (raw > MAX_S);
    unf = down && (raw < MIN_S);

    if (SATURATE == MODE_SAT) begin
      if (ovf) begin
        next_count = WIDTH'(MAX_VAL);
      end else if (unf) begin
        next_count = WIDTH'(MIN_VAL);
      end else begin
        next_count = WIDTH'(raw);
      end
    end else begin
      // Signed % follows the dividend's sign; fold negatives into range.
      rem = (raw - MIN_S) % RANGE_S;
      if (rem[AW-1]) begin
        rem = rem + RANGE_S;
      end
      next_count = WIDTH'(MIN_S + rem);
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with bounds, variable step, clear/load,
// wrap or saturate mode, terminal flags, event pulses and a sticky flag.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : control inputs and count/status outputs (slave side)
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned MAX_VAL   = (32'd1 << WIDTH) - 32'd1,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned SATURATE  = MODE_WRAP
) (
  input  logic                   clk,
  input  logic                   reset,
  updown_counter_param_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic             ovf_q;
  logic             unf_q;
  logic             lerr_q;
  logic             sticky_q;

  logic             up;
  logic             down;
  logic [WIDTH-1:0] step_cnt;
  logic             step_ovf;
  logic             step_unf;
  logic [WIDTH-1:0] load_cnt;
  logic             load_bad;

  // Counting only when enabled and exactly one direction is requested.
  assign up   = bus.enable &  bus.increment & ~bus.decrement;
  assign down = bus.enable & ~bus.increment &  bus.decrement;

  updown_counter_next #(
    .WIDTH    (WIDTH),
    .STEP_W   (STEP_W),
    .MIN_VAL  (MIN_VAL),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count_q),
    .up         (up),
    .down       (down),
    .step       (bus.step),
    .next_count (step_cnt),
    .ovf        (step_ovf),
    .unf        (step_unf)
  );

  // Out-of-range loads snap to the nearest bound and flag an error.
  always_comb begin
    load_cnt = bus.load_value;
    load_bad = 1'b0;
    if (!in_range(longint'(bus.load_value), longint'(MIN_VAL), longint'(MAX_VAL))) begin
      load_bad = 1'b1;
      load_cnt = (bus.load_value < MIN_W) ? MIN_W : MAX_W;
    end
  end

  // State and event registers; priority clear > load > count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= RST_W;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      lerr_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      lerr_q <= 1'b0;
      if (bus.clear) begin
        count_q  <= RST_W;
        sticky_q <= 1'b0;
      end else begin
        // Sticky follows a registered pulse by one cycle.
        sticky_q <= sticky_q | ovf_q | unf_q;
        if (bus.load) begin
          count_q <= load_cnt;
          lerr_q  <= load_bad;
        end else if (up || down) begin
          count_q <= step_cnt;
          ovf_q   <= step_ovf;
          unf_q   <= step_unf;
        end
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.at_max     = (count_q == MAX_W);
  assign bus.at_min     = (count_q == MIN_W);
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.load_err   = lerr_q;
  assign bus.sticky_ovf = sticky_q;

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter that generalises the team's 4-bit inc/dec counter. Adds configurable width and bounds, variable step, synchronous clear and load, and a wrap or saturate mode. Also adds terminal-count flags, overflow/underflow event pulses and a sticky overflow flag. Used as a general event/occupancy counter in datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits
STEP_W, 4, width of the step input
MIN_VAL, 0, lower bound (inclusive), must be < MAX_VAL
MAX_VAL, 2**WIDTH-1, upper bound (inclusive), must fit in WIDTH
RESET_VAL, 0, value after reset/clear; must lie in [MIN_VAL, MAX_VAL]
SATURATE, 0, 0 = wrap within [MIN_VAL, MAX_VAL]; 1 = clamp at bounds

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous return to RESET_VAL
load  in  1  synchronous load of load_value
load_value  in  WIDTH  value to load
enable  in  1  gates increment/decrement (not clear/load)
increment  in  1  count up by step
decrement  in  1  count down by step
step  in  STEP_W  step magnitude; 0 = no change
count  out  WIDTH  current count (registered)
at_max  out  1  count == MAX_VAL (combinational from count)
at_min  out  1  count == MIN_VAL (combinational from count)
overflow  out  1  one-cycle pulse: an up-step crossed MAX_VAL
underflow  out  1  one-cycle pulse: a down-step crossed MIN_VAL
load_err  out  1  one-cycle pulse: load_value was outside bounds
sticky_ovf  out  1  set by overflow or underflow; cleared by clear or reset only

Behaviour:
- Reset (reset=0, async): count=RESET_VAL; overflow, underflow, load_err, sticky_ovf = 0.
- Priority per cycle: clear > load > (enable & increment/decrement).
- clear: count<=RESET_VAL. Clears sticky_ovf. Pulses 0.
- load: count<=load_value if it lies in [MIN_VAL, MAX_VAL]. Otherwise count<=nearest bound and load_err=1 for one cycle. Load never sets overflow/underflow.
- enable=0, or increment==decrement (both 0 or both 1): count holds, no pulses.
- Latency: count and pulses update on the clock edge after the request; both are registered and aligned in the same cycle.
- Arithmetic: done at WIDTH+STEP_W+1 bits signed, so intermediates never truncate. RANGE = MAX_VAL-MIN_VAL+1.
- Wrap mode (SATURATE=0):
  - Up: count<=MIN_VAL+((count-MIN_VAL+step) mod RANGE).
  - Down: count<=MIN_VAL+((count-MIN_VAL-step) mod RANGE), result non-negative.
  - overflow/underflow pulse if the raw result left the bounds, including steps >= RANGE.
- Saturate mode (SATURATE=1): result clamped to MAX_VAL/MIN_VAL. Pulse only if clamping occurred. An up-step while already at MAX_VAL with step>0 counts as clamping and pulses overflow.
- step=0 with an active inc/dec: no change, no pulse.
- sticky_ovf: set the cycle after any overflow/underflow pulse is registered; stays set through load.
- Reset asserted mid-operation: immediate return to reset values; no pulse is emitted on release.
- Full-width default (MIN=0, MAX=2**WIDTH-1) behaves as a plain modulo-2**WIDTH counter in wrap mode.

Decomposition:
- Package counter_pkg:
  - mode localparams MODE_WRAP=0, MODE_SAT=1
  - function clog2
  - function in_range(value, min, max) for bound checks
- Sub-module updown_counter_next (purely combinational): takes count, direction, step, bounds and mode; returns next_count, ovf and unf. Top level holds the registers, priority logic, load range check and sticky flag.

Test Plan:
- WIDTH=4, MIN 0, MAX 15, wrap, step=1; reset -> count=0. Pulse clear, then 17 increments -> count=1, overflow pulses once at the 15->0 transition, sticky_ovf=1.
- WIDTH=4, MIN 2, MAX 12, wrap; load 11, step=3, increment -> count=3, overflow=1. Then decrement step=2 -> count=12, underflow=1.
- Same bounds, SATURATE=1; load 10, increment step=5 -> count=12, overflow=1, at_max=1. Increment again -> count=12, overflow=1. Decrement step=15 -> count=2, underflow=1, at_min=1.
- increment=decrement=1 with step=4 at count=7 -> count stays 7, no pulses. Same with enable=0. step=0 with increment -> no change.
- Priority: clear, load and increment in the same cycle -> count=RESET_VAL, sticky_ovf=0. Load 14 with MAX 12 -> count=12, load_err=1, overflow=0.
- Assert reset asynchronously between edges mid-count (count=9) -> count=RESET_VAL immediately, all flags 0. After release, first increment gives RESET_VAL+step.
